// File: rtl/rsa_sequencer.sv
// Bus-facing sequencer for the RSA modular-exponentiation engine: operand registers,
// arm/run control and sticky status. Define RSA_SEQ_TIMEOUT_EN to build the RUN watchdog.
module rsa_sequencer #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [1:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             start,
  input  logic             irq_ack,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             irq,
  output logic [WIDTH-1:0] result,
  output logic             eng_ena,
  output logic             eng_clear,
  output logic [WIDTH-1:0] eng_m,
  output logic [WIDTH-1:0] eng_e,
  output logic [WIDTH-1:0] eng_p,
  output logic [WIDTH-1:0] eng_c,
  input  logic             eng_eoc,
  input  logic [WIDTH-1:0] eng_result
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARM   = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_ABORT = 2'd3;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       timeout_hit;
  logic       run_done;
  logic       run_abort;

`ifdef RSA_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] run_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      run_cnt <= '0;
    else if (state == S_IDLE && start)
      run_cnt <= '0;
    else if (state == S_RUN)
      run_cnt <= run_cnt + CW'(1);
  end

  assign timeout_hit = (run_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst)
      err <= 1'b0;
    else if (state == S_IDLE && start)
      err <= 1'b0;
    else if (run_abort)
      err <= 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  // Completion takes priority over a timeout landing in the same RUN cycle.
  assign run_done  = (state == S_RUN) && eng_eoc;
  assign run_abort = (state == S_RUN) && !eng_eoc && timeout_hit;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_ARM;
      S_ARM:   state_nxt = S_RUN;
      S_RUN: begin
        if (run_done)       state_nxt = S_IDLE;
        else if (run_abort) state_nxt = S_ABORT;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      eng_m  <= '0;
      eng_e  <= '0;
      eng_p  <= '0;
      eng_c  <= '0;
      result <= '0;
      done   <= 1'b0;
      irq    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && wr_en) begin
        case (wr_addr)
          2'd0:    eng_m <= wr_data;
          2'd1:    eng_e <= wr_data;
          2'd2:    eng_p <= wr_data;
          default: eng_c <= wr_data;
        endcase
      end
      if (state == S_IDLE && start)
        done <= 1'b0;
      else if (run_done)
        done <= 1'b1;
      if (run_done)
        result <= eng_result;
      if (run_done || run_abort)
        irq <= 1'b1;
      else if (irq_ack)
        irq <= 1'b0;
    end
  end

  assign busy      = (state != S_IDLE);
  assign eng_ena   = (state != S_IDLE);
  assign eng_clear = !(state == S_ARM || state == S_ABORT);

endmodule

// File: tb/tb_rsa_sequencer.sv
// Bench for rsa_sequencer: per-cycle comparison against a phase-level model plus
// directed literal checks. Timeout scenario built when RSA_SEQ_TIMEOUT_EN is defined.
module tb_rsa_sequencer;

  localparam int W  = 8;
  localparam int TO = 16;
`ifdef RSA_SEQ_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif
  localparam int RUN_LEN = TMO_ON ? 10 : 100;
  localparam int RST_AT  = TMO_ON ? 8 : 50;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, wr_en, start, irq_ack, eng_eoc;
  logic [1:0]   wr_addr;
  logic [W-1:0] wr_data, eng_result;
  logic         busy, done, err, irq, eng_ena, eng_clear;
  logic [W-1:0] result, eng_m, eng_e, eng_p, eng_c;

  rsa_sequencer #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .irq_ack(irq_ack), .busy(busy), .done(done), .err(err),
    .irq(irq), .result(result), .eng_ena(eng_ena), .eng_clear(eng_clear),
    .eng_m(eng_m), .eng_e(eng_e), .eng_p(eng_p), .eng_c(eng_c),
    .eng_eoc(eng_eoc), .eng_result(eng_result)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: which phase of a conversion the sequencer is in, plus the spec's sticky flags.
  typedef enum int {PH_IDLE, PH_ARM, PH_RUN, PH_ABORT} phase_t;
  phase_t       ph = PH_IDLE;
  logic [W-1:0] m_reg [4];
  logic [W-1:0] m_result;
  bit           m_done, m_err, m_irq, m_valid = 1'b0, fin, tmo;
  int           m_run;

  always @(posedge clk) begin
    if (rst) begin
      ph = PH_IDLE;
      for (int i = 0; i < 4; i++) m_reg[i] = '0;
      m_result = '0; m_done = 0; m_err = 0; m_irq = 0; m_run = 0;
      m_valid = 1'b1;
    end else begin
      fin = 0; tmo = 0;
      case (ph)
        PH_IDLE: begin
          if (wr_en) m_reg[wr_addr] = wr_data;
          if (start) begin ph = PH_ARM; m_done = 0; m_err = 0; end
        end
        PH_ARM: begin ph = PH_RUN; m_run = 0; end
        PH_RUN: begin
          m_run++;
          if (eng_eoc) fin = 1;
          else if (TMO_ON && m_run == TO) tmo = 1;
          if (fin) begin m_result = eng_result; m_done = 1; ph = PH_IDLE; end
          if (tmo) begin m_err = 1; ph = PH_ABORT; end
        end
        default: ph = PH_IDLE;
      endcase
      if (fin || tmo) m_irq = 1;
      else if (irq_ack) m_irq = 0;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("busy", busy, ph != PH_IDLE);
      check("eng_ena", eng_ena, ph != PH_IDLE);
      check("eng_clear", eng_clear, !(ph == PH_ARM || ph == PH_ABORT));
      check("done", done, m_done);
      check("err", err, m_err);
      check("irq", irq, m_irq);
      check("result", result, m_result);
      check("eng_m", eng_m, m_reg[0]);
      check("eng_e", eng_e, m_reg[1]);
      check("eng_p", eng_p, m_reg[2]);
      check("eng_c", eng_c, m_reg[3]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [W-1:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 0;
  endtask

  task automatic finish_run(input logic [W-1:0] r);
    eng_eoc = 1; eng_result = r;
    tick();
    eng_eoc = 0;
  endtask

  initial begin
    rst = 1; wr_en = 0; wr_addr = '0; wr_data = '0; start = 0;
    irq_ack = 0; eng_eoc = 0; eng_result = '0;
    tick(); tick();
    rst = 0;
    check("rst busy", busy, 0);
    check("rst ena", eng_ena, 0);
    check("rst clear", eng_clear, 1);
    check("rst result", result, 0);
    check("rst irq", irq, 0);

    // C = R^2 mod M with R = 256, M = 187 -> 86
    wr(2'd0, 8'd187); wr(2'd1, 8'd3); wr(2'd2, 8'd5); wr(2'd3, 8'd86);
    check("rd M", eng_m, 187);
    check("rd E", eng_e, 3);
    check("rd P", eng_p, 5);
    check("rd C", eng_c, 86);

    eng_eoc = 1; eng_result = 8'd99;
    tick();
    eng_eoc = 0;
    check("idle eoc result", result, 0);
    check("idle eoc done", done, 0);

    // normal run: 5^3 mod 187 = 125
    start = 1; tick(); start = 0;
    check("arm clear", eng_clear, 0);
    check("arm busy", busy, 1);
    tick();
    check("run clear", eng_clear, 1);
    repeat (RUN_LEN - 2) tick();
    finish_run(8'd125);
    check("run1 result", result, 125);
    check("run1 done", done, 1);
    check("run1 irq", irq, 1);
    check("run1 busy", busy, 0);

    // busy protection
    start = 1; tick(); start = 0;
    tick(); tick();
    wr(2'd2, 8'd9);
    start = 1; tick(); start = 0;
    check("busy wr P", eng_p, 5);
    check("busy start clear", eng_clear, 1);
    repeat (3) tick();
    finish_run(8'd125);
    check("run2 result", result, 125);
    check("run2 done", done, 1);

    irq_ack = 1; tick(); irq_ack = 0;
    check("ack irq", irq, 0);

    // irq set wins over simultaneous ack
    start = 1; tick(); start = 0;
    repeat (4) tick();
    irq_ack = 1;
    finish_run(8'd7);
    check("prio irq", irq, 1);
    check("prio result", result, 7);
    tick(); irq_ack = 0;
    check("late ack irq", irq, 0);
    check("late ack done", done, 1);

    // reset mid-run
    start = 1; tick(); start = 0;
    repeat (RST_AT) tick();
    check("pre-rst busy", busy, 1);
    rst = 1; tick(); rst = 0;
    check("mid rst busy", busy, 0);
    check("mid rst ena", eng_ena, 0);
    check("mid rst M", eng_m, 0);
    check("mid rst P", eng_p, 0);
    start = 1; tick(); start = 0;
    check("rearm clear", eng_clear, 0);
    tick(); tick();
    finish_run(8'd42);

    // back-to-back start in first IDLE cycle
    start = 1; tick(); start = 0;
    check("b2b clear", eng_clear, 0);
    check("b2b done cleared", done, 0);
    check("b2b result", result, 42);
    irq_ack = 1; tick(); irq_ack = 0;
`ifdef RSA_SEQ_TIMEOUT_EN
    eng_result = 8'd200;
    repeat (TO - 1) tick();
    check("tmo last run clear", eng_clear, 1);
    tick();
    check("abort clear", eng_clear, 0);
    check("abort busy", busy, 1);
    tick();
    check("tmo busy", busy, 0);
    check("tmo err", err, 1);
    check("tmo done", done, 0);
    check("tmo irq", irq, 1);
    check("tmo result", result, 42);
`else
    repeat (5) tick();
    finish_run(8'd55);
    check("b2b fin result", result, 55);
    check("b2b fin done", done, 1);
    check("b2b fin err", err, 0);
`endif
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rsa_sequencer.md
# rsa_sequencer

Bus-facing sequencer for the RSA modular-exponentiation engine. It holds the operand registers (modulus, exponent, plaintext, Montgomery constant) written by the peripheral bus, and on a start command arms the engine through its active-low `clear` and its `ena`. It then watches for end-of-conversion, captures the result and raises done/interrupt status. It sits between the tinyQV peripheral register decode and the engine's control/datapath.

## Interface
Parameters:
- `WIDTH`, 8, operand/result width in bits; must match the engine.
- `TIMEOUT`, 4096, maximum RUN cycles before abort; used only with `RSA_SEQ_TIMEOUT_EN`.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `wr_en`  in  1  operand register write strobe.
- `wr_addr`  in  2  selects the register: 0 = M, 1 = E, 2 = P, 3 = C (constant).
- `wr_data`  in  WIDTH  write data.
- `start`  in  1  single-cycle start request.
- `irq_ack`  in  1  clears `irq`.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  sticky; the last run completed.
- `err`  out  1  sticky; the last run timed out.
- `irq`  out  1  sticky interrupt flag.
- `result`  out  WIDTH  captured engine result.
- `eng_ena`  out  1  engine enable.
- `eng_clear`  out  1  engine clear, active-low.
- `eng_m`, `eng_e`, `eng_p`, `eng_c`  out  WIDTH each  operand registers, driven continuously.
- `eng_eoc`  in  1  engine end-of-conversion.
- `eng_result`  in  WIDTH  engine output.

## Operation
State machine: IDLE, ARM, RUN, ABORT.

Engine control outputs per state:
- IDLE: `eng_ena`=0, `eng_clear`=1.
- ARM: `eng_ena`=1, `eng_clear`=0.
- RUN: `eng_ena`=1, `eng_clear`=1.
- ABORT: `eng_ena`=1, `eng_clear`=0.

Transitions:
- IDLE→ARM on `start`=1. The same edge clears `done` and `err`.
- ARM→RUN unconditionally. The single ARM cycle forces the engine FSM back to its reset state.
- RUN→IDLE on `eng_eoc`=1. That edge loads `result`←`eng_result`, sets `done`=1 and sets `irq`=1.
- RUN→ABORT on timeout (see Configuration). That edge sets `err`=1 and `irq`=1; `result` is unchanged.
- ABORT→IDLE unconditionally. The engine is left held in its reset state.

Operand writes:
- Accepted only when `busy`=0. Writes while busy are dropped; the registers keep their values.
- A write and `start` in the same IDLE cycle: the write lands on that edge and the run uses the new value.

Other rules:
- `start` while busy is ignored; there is no queueing.
- `irq`: if set and `irq_ack` occur in the same cycle, set wins.
- `eng_eoc` outside RUN is ignored.

Reset (`rst`=1 at an edge, including mid-run):
- State goes to IDLE.
- M, E, P, C, `result`, `done`, `err`, `irq` and the timeout counter all go to 0.
- Outputs therefore read `busy`=0, `eng_ena`=0, `eng_clear`=1.

## Timing
- `start` sampled at edge k: ARM is cycle k→k+1, RUN begins at edge k+1, and `busy`=1 from k onward.
- `eng_eoc` sampled high at edge n: `result`, `done` and `irq` are valid, and `busy`=0, from edge n onward (one cycle after `eng_eoc` is first driven).
- Back-to-back runs: `start` is accepted in the first IDLE cycle after completion.
- All status outputs are registered or decoded directly from the state register. There is no combinational path from `start` or `eng_eoc` to any output.

## Configuration
`RSA_SEQ_TIMEOUT_EN`:
- Defined:
  - A RUN-cycle counter of width `$clog2(TIMEOUT+1)` clears on entry to ARM and increments every RUN cycle.
  - When the counter equals `TIMEOUT`-1 and `eng_eoc`=0, the next state is ABORT.
  - If `eng_eoc`=1 in that same cycle, completion wins.
- Undefined:
  - No counter is built; RUN waits indefinitely for `eng_eoc`.
  - `err` is tied to 0 and ABORT is unreachable.

## Test plan
- **Reset values:** assert `rst` → all outputs 0 except `eng_clear`=1. Then write M=187, E=3, P=5, C=R²mod M and read back via `eng_m`/`eng_e`/`eng_p`/`eng_c` → 187, 3, 5, C.
- **Normal run:** pulse `start` at edge k → `eng_clear`=0 only during cycle k→k+1. Engine model drives `eng_eoc` with `eng_result`=125 after 100 cycles → `result`=125, `done`=1, `irq`=1, `busy`=0 one cycle later.
- **Busy protection:** during RUN, write P=9 and pulse `start` → `eng_p` stays 5, there is no second ARM, and completion proceeds normally.
- **Interrupt priority:** pulse `irq_ack` in the same cycle as `eng_eoc` → `irq`=1. Pulse `irq_ack` on the next cycle → `irq`=0, while `done` stays 1.
- **Reset mid-run:** assert `rst` in RUN cycle 50 → next cycle IDLE, `eng_ena`=0, operands 0. A new `start` re-arms with a fresh ARM cycle.
- **Timeout (`RSA_SEQ_TIMEOUT_EN`, `TIMEOUT`=16):** hold `eng_eoc`=0 → after 16 RUN cycles, ABORT for one cycle (`eng_clear`=0), then IDLE with `err`=1, `done`=0, `irq`=1, `result` unchanged.
